// File: rtl/sext_arbiter_if.sv
// Handshake bundle between two extension requesters, the shared arbiter and the result consumer.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface sext_arbiter_if #(
   parameter int REGISTER_DATA_BIT_WIDTH = 16
);
   logic                               req0_valid;
   logic                               req0_ready;
   logic [REGISTER_DATA_BIT_WIDTH-1:0] req0_data;
   logic [1:0]                         req0_mode;

   logic                               req1_valid;
   logic                               req1_ready;
   logic [REGISTER_DATA_BIT_WIDTH-1:0] req1_data;
   logic [1:0]                         req1_mode;

   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [REGISTER_DATA_BIT_WIDTH-1:0] rsp_data;
   logic                               rsp_id;

   modport slave (
      input  req0_valid, req0_data, req0_mode,
      output req0_ready,
      input  req1_valid, req1_data, req1_mode,
      output req1_ready,
      output rsp_valid, rsp_data, rsp_id,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_data, req0_mode,
      input  req0_ready,
      output req1_valid, req1_data, req1_mode,
      input  req1_ready,
      input  rsp_valid, rsp_data, rsp_id,
      output rsp_ready
   );
endinterface

// File: rtl/sext_arbiter.sv
// Two-requester round-robin arbiter in front of one shared sign/zero-extension unit
// with a single-entry output register.
//
// state    | meaning
// ST_EMPTY | output register empty, rsp_valid = 0
// ST_FULL  | output register holds a result, rsp_valid = 1
module sext_arbiter #(
   parameter int REGISTER_DATA_BIT_WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   sext_arbiter_if.slave bus
);
   localparam int W = REGISTER_DATA_BIT_WIDTH;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_last_grant;
   logic           r_rsp_id;
   logic [W-1:0]   r_rsp_data;

   logic           w_can_accept;
   logic           w_grant;
   logic           w_ready0;
   logic           w_ready1;
   logic           w_xfer;
   logic [W-1:0]   w_sel_data;
   logic [1:0]     w_sel_mode;
   logic [W-1:0]   w_ext_data;

   // rst_n gates acceptance so no handshake can be reported while reset is held
   assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | bus.rsp_ready);

   always_comb begin
      w_grant = 1'b0;
      case ({bus.req1_valid, bus.req0_valid})
         2'b01:   w_grant = 1'b0;
         2'b10:   w_grant = 1'b1;
         2'b11:   w_grant = ~r_last_grant;
         default: w_grant = 1'b0;
      endcase
   end

   assign w_ready0 = w_can_accept & (w_grant == 1'b0);
   assign w_ready1 = w_can_accept & (w_grant == 1'b1);
   assign w_xfer   = (bus.req0_valid & w_ready0) | (bus.req1_valid & w_ready1);

   assign w_sel_data = w_grant ? bus.req1_data : bus.req0_data;
   assign w_sel_mode = w_grant ? bus.req1_mode : bus.req0_mode;

   always_comb begin
      w_ext_data = '0;
      case (w_sel_mode)
         2'b00:   w_ext_data = {{(W-4){w_sel_data[3]}},  w_sel_data[3:0]};
         2'b01:   w_ext_data = {{(W-8){w_sel_data[7]}},  w_sel_data[7:0]};
         2'b10:   w_ext_data = {{(W-12){w_sel_data[11]}}, w_sel_data[11:0]};
         2'b11:   w_ext_data = {{(W-8){1'b0}},           w_sel_data[7:0]};
         default: w_ext_data = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
         ST_FULL:  if (bus.rsp_ready && !w_xfer) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result register and round-robin pointer only move on an accepted field
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_data   <= '0;
         r_rsp_id     <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_xfer) begin
         r_rsp_data   <= w_ext_data;
         r_rsp_id     <= w_grant;
         r_last_grant <= w_grant;
      end
   end

   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;
   assign bus.rsp_valid  = (r_state == ST_FULL);
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_id     = r_rsp_id;
endmodule
